// File: rtl/plab5_mcore_mem_domain_arb.sv
// Two-port domain-aware arbiter in front of the single-ported test memory.
// Port 0 is the public requester (domain 0) and port 1 is the secure
// requester (domain 1). An order FIFO records the issuing port of every
// in-flight request so that in-order responses can be steered back, and a
// sticky flag records any response whose reported domain disagrees.
module plab5_mcore_mem_domain_arb #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_max_inflight = 2,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int cq            = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int cr            = 3 + p_opaque_nbits + 2 + c_len_nbits,
    localparam int n             = $clog2(p_max_inflight + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sec_lock,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [cq-1:0]           req0_control,
    input  logic [p_data_nbits-1:0] req0_data,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [cq-1:0]           req1_control,
    input  logic [p_data_nbits-1:0] req1_data,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [cq-1:0]           memreq_control,
    output logic [p_data_nbits-1:0] memreq_data,
    output logic                    memreq_domain,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [cr-1:0]           memresp_control,
    input  logic [p_data_nbits-1:0] memresp_data,
    input  logic                    memresp_domain,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [cr-1:0]           resp0_control,
    output logic [p_data_nbits-1:0] resp0_data,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [cr-1:0]           resp1_control,
    output logic [p_data_nbits-1:0] resp1_data,
    output logic [n-1:0]            inflight,
    output logic                    domain_err
);

    localparam int pw = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam logic [n-1:0]  c_depth    = n'(p_max_inflight);
    localparam logic [pw-1:0] c_last_ptr = pw'(p_max_inflight - 1);

    logic [p_max_inflight-1:0] fifo_q, fifo_d;
    logic [pw-1:0]             head_q, head_d;
    logic [pw-1:0]             tail_q, tail_d;
    logic [n-1:0]              count_q, count_d;
    logic                      prio_q, prio_d;
    logic                      last_dom_q, last_dom_d;
    logic                      domain_err_q, domain_err_d;

    logic e0, e1, any_elig, sel, full, empty, can_grant, head_id;
    logic req_fire, resp_fire;

    // Arbitration and request-side muxing; all handshakes held low in reset.
    always_comb begin
        e0        = req0_val;
        e1        = req1_val & ~sec_lock;
        any_elig  = e0 | e1;
        sel       = (e0 & e1) ? prio_q : e1;
        full      = (count_q == c_depth);
        empty     = (count_q == '0);
        can_grant = reset & memreq_rdy & ~full;
        head_id   = fifo_q[head_q];

        memreq_val     = reset & any_elig;
        req0_rdy       = can_grant & any_elig & ~sel;
        req1_rdy       = can_grant & any_elig & sel;
        memreq_control = sel ? req1_control : req0_control;
        memreq_data    = sel ? req1_data : req0_data;
        memreq_domain  = any_elig ? sel : last_dom_q;
        req_fire       = can_grant & any_elig;

        memresp_rdy = reset & ~empty & (head_id ? resp1_rdy : resp0_rdy);
        resp0_val   = reset & memresp_val & ~empty & ~head_id;
        resp1_val   = reset & memresp_val & ~empty & head_id;
        resp_fire   = memresp_val & memresp_rdy;

        resp0_control = memresp_control;
        resp1_control = memresp_control;
        resp0_data    = memresp_data;
        resp1_data    = memresp_data;

        inflight   = count_q;
        domain_err = domain_err_q;
    end

    // Next-state for order FIFO, round-robin pointer, last domain and error flag.
    always_comb begin
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        prio_d       = prio_q;
        last_dom_d   = last_dom_q;
        domain_err_d = domain_err_q;

        if (req_fire) begin
            fifo_d[tail_q] = sel;
            tail_d         = (tail_q == c_last_ptr) ? '0 : tail_q + 1'b1;
            prio_d         = ~sel;
            last_dom_d     = sel;
        end
        if (resp_fire) begin
            head_d = (head_q == c_last_ptr) ? '0 : head_q + 1'b1;
            if (memresp_domain != head_id)
                domain_err_d = 1'b1;
        end
        if (req_fire && !resp_fire)
            count_d = count_q + 1'b1;
        else if (!req_fire && resp_fire)
            count_d = count_q - 1'b1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            prio_q       <= 1'b0;
            last_dom_q   <= 1'b0;
            domain_err_q <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            prio_q       <= prio_d;
            last_dom_q   <= last_dom_d;
            domain_err_q <= domain_err_d;
        end
    end

endmodule

// File: tb/tb_plab5_mcore_mem_domain_arb.sv
// Directed bench for plab5_mcore_mem_domain_arb with hand-computed expectations.
module tb_plab5_mcore_mem_domain_arb;

    localparam int O  = 8;
    localparam int A  = 32;
    localparam int D  = 32;
    localparam int CQ = 3 + O + A + 2;
    localparam int CR = 3 + O + 2 + 2;
    localparam int N  = 2;

    logic          clk = 0;
    logic          reset;
    logic          sec_lock;
    logic          req0_val, req0_rdy, req1_val, req1_rdy;
    logic [CQ-1:0] req0_control, req1_control, memreq_control;
    logic [D-1:0]  req0_data, req1_data, memreq_data;
    logic          memreq_val, memreq_rdy, memreq_domain;
    logic          memresp_val, memresp_rdy, memresp_domain;
    logic [CR-1:0] memresp_control, resp0_control, resp1_control;
    logic [D-1:0]  memresp_data, resp0_data, resp1_data;
    logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [N-1:0]  inflight;
    logic          domain_err;

    int n_cmp = 0;
    int n_err = 0;

    plab5_mcore_mem_domain_arb dut (
        .clk(clk), .reset(reset), .sec_lock(sec_lock),
        .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req0_control(req0_control), .req0_data(req0_data),
        .req1_val(req1_val), .req1_rdy(req1_rdy),
        .req1_control(req1_control), .req1_data(req1_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_control(memreq_control), .memreq_data(memreq_data),
        .memreq_domain(memreq_domain),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .memresp_control(memresp_control), .memresp_data(memresp_data),
        .memresp_domain(memresp_domain),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp0_control(resp0_control), .resp0_data(resp0_data),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .resp1_control(resp1_control), .resp1_data(resp1_data),
        .inflight(inflight), .domain_err(domain_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 0; sec_lock = 0;
        req0_val = 1; req1_val = 1; memreq_rdy = 1;
        req0_control = 45'h111; req1_control = 45'h222;
        req0_data = 32'hAAAA_0000; req1_data = 32'hBBBB_1111;
        memresp_val = 1; memresp_domain = 0;
        memresp_control = 47'h5A5; memresp_data = 32'hCAFE_F00D;
        resp0_rdy = 1; resp1_rdy = 1;

        // Reset: handshakes forced low even with everything asserted.
        tick(); tick();
        chk("rst_memreq_val", memreq_val, 0);
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_req1_rdy", req1_rdy, 0);
        chk("rst_memresp_rdy", memresp_rdy, 0);
        chk("rst_resp0_val", resp0_val, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_domain_err", domain_err, 0);

        // Alternation: both valid, memory answers the previous request each cycle.
        reset = 1; memresp_val = 0; settle();
        chk("alt0_req0_rdy", req0_rdy, 1);
        chk("alt0_req1_rdy", req1_rdy, 0);
        chk("alt0_dom", memreq_domain, 0);
        chk("alt0_ctrl", memreq_control, 45'h111);
        chk("alt0_data", memreq_data, 32'hAAAA_0000);
        chk("empty_memresp_rdy", memresp_rdy, 0);
        tick();
        chk("alt0_inflight", inflight, 1);
        memresp_val = 1; memresp_domain = 0; settle();
        chk("alt1_req1_rdy", req1_rdy, 1);
        chk("alt1_dom", memreq_domain, 1);
        chk("alt1_ctrl", memreq_control, 45'h222);
        chk("alt1_resp0_val", resp0_val, 1);
        chk("alt1_resp1_val", resp1_val, 0);
        chk("alt1_resp_ctrl", resp1_control, 47'h5A5);
        chk("alt1_resp_data", resp0_data, 32'hCAFE_F00D);
        tick();
        chk("alt1_inflight", inflight, 1);
        memresp_domain = 1; settle();
        chk("alt2_req0_rdy", req0_rdy, 1);
        chk("alt2_dom", memreq_domain, 0);
        chk("alt2_resp1_val", resp1_val, 1);
        chk("alt2_resp0_val", resp0_val, 0);
        tick();
        memresp_domain = 0; settle();
        chk("alt3_req1_rdy", req1_rdy, 1);
        chk("alt3_dom", memreq_domain, 1);
        chk("alt3_resp0_val", resp0_val, 1);
        tick();
        req0_val = 0; req1_val = 0; memresp_domain = 1; settle();
        chk("idle_memreq_val", memreq_val, 0);
        chk("idle_dom_hold", memreq_domain, 1);
        chk("alt4_resp1_val", resp1_val, 1);
        tick();
        chk("alt_drain_inflight", inflight, 0);
        chk("alt_domain_err", domain_err, 0);

        // Empty FIFO ignores a spurious response.
        memresp_val = 1; settle();
        chk("empty_rdy", memresp_rdy, 0);
        chk("empty_resp0_val", resp0_val, 0);
        chk("empty_resp1_val", resp1_val, 0);

        // Full back-pressure: only port 1 valid, no responses.
        memresp_val = 0; req1_val = 1; settle();
        chk("full0_req1_rdy", req1_rdy, 1);
        tick();
        chk("full1_req1_rdy", req1_rdy, 1);
        tick();
        chk("full_inflight", inflight, 2);
        chk("full_req1_rdy", req1_rdy, 0);
        chk("full_memreq_val", memreq_val, 1);
        memresp_val = 1; memresp_domain = 1; settle();
        chk("full_pop_req1_rdy", req1_rdy, 0);
        chk("full_pop_memresp_rdy", memresp_rdy, 1);
        chk("full_pop_resp1_val", resp1_val, 1);
        tick();
        chk("after_pop_inflight", inflight, 1);
        memresp_val = 0; settle();
        chk("after_pop_req1_rdy", req1_rdy, 1);
        req1_val = 0;

        // Response stall: head is port 1 with its requester not ready.
        memresp_val = 1; resp1_rdy = 0; settle();
        chk("stall_memresp_rdy", memresp_rdy, 0);
        chk("stall_resp1_val", resp1_val, 1);
        tick();
        chk("stall_inflight", inflight, 1);
        resp1_rdy = 1; settle();
        chk("unstall_memresp_rdy", memresp_rdy, 1);
        tick();
        chk("unstall_inflight", inflight, 0);

        // Lock: port 1 never granted; memory drains port 0 responses.
        memresp_val = 0; sec_lock = 1; req0_val = 1; req1_val = 1; memresp_domain = 0; settle();
        chk("lock0_req0_rdy", req0_rdy, 1);
        chk("lock0_req1_rdy", req1_rdy, 0);
        chk("lock0_dom", memreq_domain, 0);
        tick();
        memresp_val = 1; settle();
        chk("lock1_req0_rdy", req0_rdy, 1);
        chk("lock1_req1_rdy", req1_rdy, 0);
        tick();
        chk("lock2_req0_rdy", req0_rdy, 1);
        chk("lock2_req1_rdy", req1_rdy, 0);
        chk("lock2_resp0_val", resp0_val, 1);
        tick();
        req0_val = 0; req1_val = 0; settle();
        chk("lock_drain_inflight", inflight, 1);
        tick();
        chk("lock_done_inflight", inflight, 0);
        sec_lock = 0; memresp_val = 0;

        // Mismatch: port 0 request answered with domain 1.
        req0_val = 1; settle();
        chk("mm_req0_rdy", req0_rdy, 1);
        tick();
        req0_val = 0; memresp_val = 1; memresp_domain = 1; settle();
        chk("mm_resp0_val", resp0_val, 1);
        chk("mm_resp1_val", resp1_val, 0);
        chk("mm_err_before", domain_err, 0);
        tick();
        chk("mm_err_set", domain_err, 1);
        memresp_val = 0;
        tick(); tick();
        chk("mm_err_sticky", domain_err, 1);

        // Reset mid-flight: prio is 1 here, so the two grants go 1 then 0.
        req0_val = 1; req1_val = 1; settle();
        chk("mf0_req1_rdy", req1_rdy, 1);
        tick();
        chk("mf1_req0_rdy", req0_rdy, 1);
        tick();
        chk("mf_inflight", inflight, 2);
        reset = 0; memresp_val = 1; memresp_domain = 1; settle();
        chk("mfrst_memreq_val", memreq_val, 0);
        chk("mfrst_req0_rdy", req0_rdy, 0);
        chk("mfrst_memresp_rdy", memresp_rdy, 0);
        chk("mfrst_resp1_val", resp1_val, 0);
        tick();
        chk("mfrst_inflight", inflight, 0);
        chk("mfrst_domain_err", domain_err, 0);
        reset = 1; memresp_val = 0; settle();
        chk("mfrst_prio_req0_rdy", req0_rdy, 1);
        chk("mfrst_prio_req1_rdy", req1_rdy, 0);
        chk("mfrst_dom", memreq_domain, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/plab5_mcore_mem_domain_arb.md
# plab5_mcore_mem_domain_arb

Two-port, domain-aware request arbiter and response router placed directly upstream of the unified single-ported test memory. It merges a public requester (port 0, domain 0) and a secure requester (port 1, domain 1) onto the memory's single val/rdy request port, and drives `memreq_domain` with the granted port's domain. It records the issuing port of every in-flight request in an order FIFO, and uses that FIFO to steer in-order responses back to the correct requester. A sticky error flag is raised if the memory's returned `memresp_domain` disagrees with the recorded issuer.

## Interface
- `p_opaque_nbits`, 8, opaque field bits (o)
- `p_addr_nbits`, 32, address bits (a)
- `p_data_nbits`, 32, data bits (d)
- `p_max_inflight`, 2, order-FIFO depth; power of two, ≥1
- Derived widths:
  - `cq` = `VC_MEM_REQ_MSG_NBITS(o,a,d)` − d
  - `cr` = `VC_MEM_RESP_MSG_NBITS(o,d)` − d
  - `n` = `$clog2(p_max_inflight+1)`
- Clock and reset: clock `clk`; reset `reset`, synchronous, active-low.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-low reset
- `sec_lock`  in  1  when 1, port 1 is never granted
- `req0_val` / `req1_val`  in  1  requester valid
- `req0_rdy` / `req1_rdy`  out  1  requester ready (grant)
- `req0_control` / `req1_control`  in  cq  request control
- `req0_data` / `req1_data`  in  d  request data
- `memreq_val`  out  1  to memory
- `memreq_rdy`  in  1  from memory
- `memreq_control`  out  cq  muxed control
- `memreq_data`  out  d  muxed data
- `memreq_domain`  out  1  granted port index
- `memresp_val`  in  1  from memory
- `memresp_rdy`  out  1  to memory
- `memresp_control`  in  cr  response control
- `memresp_data`  in  d  response data
- `memresp_domain`  in  1  domain reported by memory
- `resp0_val` / `resp1_val`  out  1  routed response valid
- `resp0_rdy` / `resp1_rdy`  in  1  requester ready
- `resp0_control` / `resp1_control`  out  cr  broadcast `memresp_control`
- `resp0_data` / `resp1_data`  out  d  broadcast `memresp_data`
- `inflight`  out  n  current order-FIFO occupancy
- `domain_err`  out  1  sticky mismatch flag

## Operation
- **Eligibility.** e0 = `req0_val`; e1 = `req1_val` & !`sec_lock`.
- **Grant condition.** A grant can occur only when `memreq_rdy`=1 and the FIFO is not full.
- **Round-robin.** 1-bit priority pointer `prio`:
  - If both ports are eligible, grant port `prio`.
  - Otherwise grant the single eligible port.
  - On each grant fire, `prio` ← the non-granted port.
- **Request outputs.**
  - `memreq_val` = e0|e1 (with the grant condition applied to `rdy` only).
  - `reqN_rdy` = 1 only for the granted port.
  - `memreq_control`, `memreq_data` and `memreq_domain` select the port that would be granted.
  - When neither port is eligible, `memreq_domain` holds its last granted value (register `last_dom`).
- **Order FIFO.**
  - Push the granted port id on request fire (`memreq_val` & `memreq_rdy` & grant).
  - Pop on response fire (`memresp_val` & `memresp_rdy`).
- **Response routing.**
  - `memresp_rdy` = FIFO non-empty & `resp[head]_rdy`.
  - `respN_val` = `memresp_val` & non-empty & head==N.
  - Control and data are broadcast to both ports.
- **Domain check.** On response fire, if `memresp_domain` ≠ head, set `domain_err`=1. The flag stays set until reset. Routing still follows head.

## Timing
- **Reset** (reset==0 at a posedge):
  - FIFO empty, `inflight`=0, `prio`=0, `last_dom`=0, `domain_err`=0.
  - While reset==0, all `*_rdy` and `*_val` outputs are forced to 0.
- **Latency.**
  - Request path is combinational: zero-cycle request → `memreq`.
  - Response path is combinational: `memresp` → `respN`.
  - Only the FIFO, `prio`, `last_dom` and `domain_err` are registered.
- **Full FIFO** (`inflight`==`p_max_inflight`): no grant, even if a pop occurs in the same cycle.
- **Empty FIFO:** `memresp_rdy`=0 and both `respN_val`=0 regardless of `memresp_val`.
- **Simultaneous push and pop** when not full: both take effect and `inflight` is unchanged.
- **Pointers** wrap modulo `p_max_inflight`.
- **`sec_lock`** is sampled combinationally. Port 1 requests already issued still receive their responses.
- **Stall:** `memreq_rdy`=0 leaves `prio` unchanged.

## Test plan
- **Alternation.** Reset, then `req0_val`=`req1_val`=1 for 4 cycles with `memreq_rdy`=1 and the memory responding each cycle.
  - Grants: 0,1,0,1.
  - `memreq_domain`: 0,1,0,1.
  - Responses arrive at resp0, resp1, resp0, resp1.
- **Full back-pressure.** `p_max_inflight`=2, `memresp_val`=0, only port 1 valid.
  - Two grants, `inflight`=2, then `req1_rdy`=0 until the first response fires.
- **Lock.** `sec_lock`=1 with both valid: only port 0 is granted for 3 cycles and `req1_rdy` stays 0.
- **Mismatch.** Issue a port 0 request, then return a response with `memresp_domain`=1.
  - `resp0_val`=1 and `domain_err` is 1 from the next cycle.
  - Flag persists until reset==0.
- **Response stall.** Head=1 and `resp1_rdy`=0 while `memresp_val`=1.
  - `memresp_rdy`=0, `inflight` held.
  - Raising `resp1_rdy` pops the entry.
- **Reset mid-flight.** `inflight`=2, assert reset for 1 cycle.
  - `inflight`=0, `prio`=0, all val/rdy outputs 0 during reset.
